// File: rtl/iter_shifter.sv
// Iterative shift unit: shifts at most STEP bits per cycle under a
// start/done handshake. Supports SLL, SRL, SRA and rotate-right.
module iter_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  localparam int unsigned SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] OpSll  = 2'b00;
  localparam logic [1:0] OpSrl  = 2'b01;
  localparam logic [1:0] OpSra  = 2'b10;

  // One extra bit so STEP == WIDTH and WIDTH itself are representable.
  localparam logic [SHW:0] StepK  = (SHW+1)'(STEP);
  localparam logic [SHW:0] WidthK = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [SHW:0]     k;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  assign ready  = (state_q == StIdle) || (state_q == StDone);
  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign accept = start && ready;

  // Step amount and the working register shifted by it for the latched op.
  always_comb begin
    k = ({1'b0, rem_q} > StepK) ? StepK : {1'b0, rem_q};
    shifted = work_q;
    if (k != '0) begin
      unique case (op_q)
        OpSll:   shifted = work_q << k;
        OpSrl:   shifted = work_q >> k;
        // Arithmetic shift replicates the current MSB, which is the original sign.
        OpSra:   shifted = $signed(work_q) >>> k;
        default: shifted = (work_q >> k) | (work_q << (WidthK - k));
      endcase
    end
  end

  // Next-state logic: accept, iterate, publish result on the final step.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    rem_d    = rem_q;
    result_d = result_q;
    unique case (state_q)
      StShift: begin
        work_d = shifted;
        rem_d  = rem_q - k[SHW-1:0];
        if (rem_q == k[SHW-1:0]) begin
          state_d  = StDone;
          result_d = shifted;
        end
      end
      StIdle, StDone: begin
        if (accept) begin
          op_d   = op;
          work_d = data_in;
          rem_d  = shamt;
          if (shamt == '0) begin
            state_d  = StDone;
            result_d = data_in;
          end else begin
            state_d = StShift;
          end
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset wins over everything, dropping any in-flight shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= 2'b00;
      work_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter with a result scoreboard; one DUT at
// STEP=1 and one at STEP=4 share clock, reset and operand inputs.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] data = '0;
  logic [4:0]  shamt = '0;

  logic        ready1, busy1, done1;
  logic        ready4, busy4, done4;
  logic [31:0] result1, result4;

  logic        sel = 1'b0;
  logic        ready_s, busy_s, done_s;
  logic [31:0] result_s;

  int          total = 0;
  int          bad = 0;
  int          done_cnt1 = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  iter_shifter #(.WIDTH(32), .STEP(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .data_in(data), .shamt(shamt),
    .ready(ready1), .busy(busy1), .done(done1), .result(result1)
  );

  iter_shifter #(.WIDTH(32), .STEP(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .op(op), .data_in(data), .shamt(shamt),
    .ready(ready4), .busy(busy4), .done(done4), .result(result4)
  );

  assign ready_s  = sel ? ready4  : ready1;
  assign busy_s   = sel ? busy4   : busy1;
  assign done_s   = sel ? done4   : done1;
  assign result_s = sel ? result4 : result1;

  always @(posedge clk) if (done1) done_cnt1++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d,
                                        input int s);
    case (o)
      2'b00:   model = d << s;
      2'b01:   model = d >> s;
      2'b10:   model = $signed(d) >>> s;
      default: model = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, check latency, busy/ready and the scoreboarded result.
  task automatic do_op(input bit s4, input logic [1:0] o, input logic [31:0] d,
                       input logic [4:0] sh, input logic [31:0] exp, input string tag);
    int n;
    int cnt;
    sel   = s4;
    n     = s4 ? (int'(sh) + 3) / 4 : int'(sh);
    op    = o;
    data  = d;
    shamt = sh;
    if (s4) start4 = 1'b1;
    else    start1 = 1'b1;
    check1({tag, " ready_pre"}, ready_s, 1'b1);
    tick();
    start1 = 1'b0;
    start4 = 1'b0;
    sb.push_back(exp);
    cnt = 0;
    while (!done_s && cnt < 64) begin
      check1({tag, " busy"}, busy_s, 1'b1);
      tick();
      cnt++;
    end
    check32({tag, " latency"}, cnt, n);
    check1({tag, " done"}, done_s, 1'b1);
    check1({tag, " busy_at_done"}, busy_s, 1'b0);
    check1({tag, " ready_at_done"}, ready_s, 1'b1);
    if (sb.size() > 0) check32({tag, " result"}, result_s, sb.pop_front());
    tick();
    check1({tag, " done_pulse_end"}, done_s, 1'b0);
    check32({tag, " result_hold"}, result_s, exp);
  endtask

  initial begin
    int cnt;
    int base;
    logic [1:0]  ro;
    logic [31:0] rd;
    logic [4:0]  rs;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check1("rst ready1", ready1, 1'b1);
    check1("rst busy1", busy1, 1'b0);
    check1("rst done1", done1, 1'b0);
    check32("rst result1", result1, 32'h0);
    check1("rst ready4", ready4, 1'b1);
    check32("rst result4", result4, 32'h0);
    rst = 1'b0;
    tick();
    tick();
    check1("idle no done", done1, 1'b0);

    // Directed cases
    do_op(1'b0, 2'b00, 32'h0FFF_FFFF, 5'd2, 32'h3FFF_FFFC, "jump_sll2");
    do_op(1'b0, 2'b10, 32'h8000_0010, 5'd4, 32'hF800_0001, "sra4");
    do_op(1'b0, 2'b01, 32'h8000_0010, 5'd4, 32'h0800_0001, "srl4");
    do_op(1'b1, 2'b11, 32'h1234_5678, 5'd9, 32'h3C09_1A2B, "rotr9_step4");
    do_op(1'b0, 2'b11, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, "zero_s1");
    do_op(1'b1, 2'b10, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, "zero_s4");
    do_op(1'b0, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, "sra31");
    do_op(1'b1, 2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, "sll31_step4");

    // Back-to-back with start held, then ignored start pulses during SHIFT
    sel = 1'b0;
    base = done_cnt1;
    op = 2'b00; data = 32'h1; shamt = 5'd1; start1 = 1'b1;
    tick();
    sb.push_back(32'h2);
    check1("b2b busy1", busy1, 1'b1);
    tick();
    check1("b2b done1", done1, 1'b1);
    check32("b2b result1", result1, sb.pop_front());
    data = 32'h1; shamt = 5'd31;
    tick();
    sb.push_back(32'h8000_0000);
    check1("b2b accept2 busy", busy1, 1'b1);
    check1("b2b accept2 no done", done1, 1'b0);
    cnt = 0;
    while (!done1 && cnt < 64) begin
      start1 = 1'($urandom_range(0, 1));
      op     = 2'($urandom);
      data   = $urandom;
      shamt  = 5'($urandom);
      tick();
      cnt++;
    end
    start1 = 1'b0;
    check32("b2b latency2", cnt, 31);
    check1("b2b done2", done1, 1'b1);
    if (sb.size() > 0) check32("b2b result2", result1, sb.pop_front());
    tick();
    check1("b2b idle busy", busy1, 1'b0);
    repeat (40) tick();
    check32("b2b done count", done_cnt1 - base, 2);

    // Reset mid-operation drops the request
    op = 2'b01; data = 32'hFFFF_FFFF; shamt = 5'd20; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    sb.push_back(model(2'b01, 32'hFFFF_FFFF, 20));
    repeat (4) tick();
    check1("mid busy before rst", busy1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check1("mid rst busy", busy1, 1'b0);
    check1("mid rst ready", ready1, 1'b1);
    check1("mid rst done", done1, 1'b0);
    check32("mid rst result", result1, 32'h0);
    base = done_cnt1;
    repeat (25) tick();
    check32("mid rst no done", done_cnt1 - base, 0);
    do_op(1'b0, 2'b01, 32'hFFFF_FFFF, 5'd20, 32'h0000_0FFF, "after_rst_srl20");

    // Simultaneous reset and start: reset wins
    rst = 1'b1; start1 = 1'b1; op = 2'b00; data = 32'h5; shamt = 5'd0;
    tick();
    rst = 1'b0; start1 = 1'b0;
    check1("rst+start ready", ready1, 1'b1);
    check1("rst+start done", done1, 1'b0);
    tick();
    check1("rst+start no done", done1, 1'b0);
    check32("rst+start result", result1, 32'h0);

    // Random operations on both step sizes against the model
    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom);
      rd = $urandom;
      rs = 5'($urandom);
      do_op(i[0], ro, rd, rs, model(ro, rd, int'(rs)), "random");
    end

    check32("scoreboard empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
